func_gen_sweep_ctrl: RTL and testbench
======================================

// Module: func_gen_sweep_ctrl
// PURPOSE
//  Frequency-sweep sequencer for the sine/cos function generator. Drives its
//  f_set/w_set/a_set inputs: steps frequency f_start->f_stop by f_step, holding
//  each point for a programmable number of sampling-clock ticks. Output is muted
//  via the generator's invalid-amplitude code when not sweeping. Sits between the
//  host/register interface and the generator inside the filter test path.
// PARAMETERS
//  F_W      19     frequency word width (Hz)
//  DWELL_W  16     dwell counter width (s_clk ticks)
//  F_MIN    1      lowest legal frequency (Hz); config values below are raised to it
//  F_MAX    50000  highest legal frequency (Hz); config values above are lowered to it
//  A_MUTE   3'b111 amplitude code that forces generator output to 0
// PORTS
//  clk        in   1        system clock
//  rst        in   1        synchronous active-high reset
//  s_clk      in   1        sampling strobe, 1-cycle pulse in clk domain (2 MHz rate)
//  start      in   1        start sweep (sampled in IDLE only)
//  abort      in   1        stop sweep immediately
//  f_start    in   F_W      first frequency
//  f_stop     in   F_W      last frequency
//  f_step     in   F_W      step size (Hz)
//  dwell      in   DWELL_W  s_clk ticks per point; 0 treated as 1
//  w_cfg      in   1        wave type for the sweep (0 sin, 1 cos)
//  a_cfg      in   3        amplitude code for the sweep (000..101)
//  f_set      out  F_W      frequency to generator
//  w_set      out  1        wave type to generator
//  a_set      out  3        amplitude to generator
//  busy       out  1        sweep in progress
//  step_pulse out  1        1-cycle pulse each time f_set changes mid-sweep
//  done       out  1        1-cycle pulse when sweep completes normally
//  cfg_err    out  1        1-cycle pulse: start rejected (f_step==0 or a_cfg>101)
// BEHAVIOUR
//  Reset: state IDLE; f_set=F_MIN, w_set=0, a_set=A_MUTE, busy/step_pulse/done/cfg_err=0.
//  States: IDLE, RUN, DONE.
//  IDLE: start=1 & config valid -> latch clamped f_start/f_stop/f_step/dwell/w_cfg/a_cfg;
//   next cycle RUN, f_set=f_start, w_set=w_cfg, a_set=a_cfg, busy=1, dwell cnt=0.
//   start=1 & config invalid -> cfg_err pulse next cycle, remain IDLE.
//  Direction: up if f_start<=f_stop, else down; f_start==f_stop is a single point.
//  RUN: dwell cnt increments on each s_clk pulse. On the s_clk pulse that makes
//   cnt == max(dwell,1): if f_set==f_stop -> DONE; else next cycle f_set +=/-= f_step,
//   clamped to f_stop (no overshoot), step_pulse=1, cnt=0. Arithmetic uses F_W+1 bits.
//  DONE: one cycle; done=1, busy=0, a_set=A_MUTE; then IDLE. f_set/w_set hold last value.
//  abort (any state, highest priority, incl. same cycle as start or dwell expiry):
//   next cycle IDLE, a_set=A_MUTE, busy=0, no done/step_pulse.
//  start while busy: ignored. Config inputs changing mid-sweep: ignored (latched copy used).
//  rst mid-sweep: all outputs to reset values next cycle.
//  All outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  SWEEP_LOOP_EN defined: at dwell expiry on f_stop, reload f_start (step_pulse=1)
//   and continue; no DONE/done pulse; sweep ends only on abort or rst.
//  SWEEP_LOOP_EN undefined: single pass, ends in DONE as described above.
// TESTING
//  1 rst, start f 1000->1400 step 100 dwell 3 sin a=001 -> f_set 1000,1100..1400, each
//    held 3 s_clk; 4 step_pulses; done 1 cycle after 3rd tick at 1400; a_set=111.
//  2 start f 5000->4000 step 300 dwell 1 -> f_set 5000,4700,4400,4100,4000 (clamp); done.
//  3 f_step=0 start -> cfg_err pulse, busy stays 0, a_set stays 111.
//  4 abort on same cycle as dwell expiry at 1200 -> IDLE, no step_pulse, no done, mute.
//  5 f_start=60000,f_stop=60000,dwell=0 -> single point f_set=50000, 1 s_clk, done.
//  6 SWEEP_LOOP_EN: 1000->1200 step 100 dwell 2 -> sequence 1000,1100,1200,1000.. no done
//    over 3 loops; abort ends it; rst mid-sweep -> f_set=1, a_set=111, busy=0.

Source files
------------

// File: rtl/func_gen_sweep_ctrl.sv
// Frequency-sweep sequencer driving f_set/w_set/a_set of the sine/cos function generator.
// Define SWEEP_LOOP_EN to wrap from f_stop back to f_start indefinitely instead of finishing.
module func_gen_sweep_ctrl #(
    parameter int         F_W     = 19,
    parameter int         DWELL_W = 16,
    parameter int         F_MIN   = 1,
    parameter int         F_MAX   = 50000,
    parameter logic [2:0] A_MUTE  = 3'b111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_clk,
    input  logic               start,
    input  logic               abort,
    input  logic [F_W-1:0]     f_start,
    input  logic [F_W-1:0]     f_stop,
    input  logic [F_W-1:0]     f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               w_cfg,
    input  logic [2:0]         a_cfg,
    output logic [F_W-1:0]     f_set,
    output logic               w_set,
    output logic [2:0]         a_set,
    output logic               busy,
    output logic               step_pulse,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [F_W-1:0] FMIN_W = F_W'(F_MIN);
    localparam logic [F_W-1:0] FMAX_W = F_W'(F_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    logic [F_W-1:0]     r_fStart;
    logic [F_W-1:0]     r_fStop;
    logic [F_W-1:0]     r_fStep;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_up;

    logic [F_W-1:0]     w_startClamp;
    logic [F_W-1:0]     w_stopClamp;
    logic [DWELL_W-1:0] w_dwellEff;
    logic [DWELL_W-1:0] w_cntNext;
    logic               w_cfgValid;
    logic [F_W:0]       w_sum;
    logic [F_W:0]       w_diff;
    logic [F_W-1:0]     w_nextFreq;

    always_comb begin
        w_startClamp = f_start;
        if (f_start < FMIN_W)
            w_startClamp = FMIN_W;
        else if (f_start > FMAX_W)
            w_startClamp = FMAX_W;

        w_stopClamp = f_stop;
        if (f_stop < FMIN_W)
            w_stopClamp = FMIN_W;
        else if (f_stop > FMAX_W)
            w_stopClamp = FMAX_W;

        w_cfgValid = (f_step != '0) && (a_cfg <= 3'd5);
        w_dwellEff = (dwell == '0) ? DWELL_W'(1) : dwell;
        w_cntNext  = r_cnt + DWELL_W'(1);

        // One extra bit so a step past either end is seen as overshoot, not wrap-around.
        w_sum  = {1'b0, f_set} + {1'b0, r_fStep};
        w_diff = {1'b0, f_set} - {1'b0, r_fStep};
        if (r_up)
            w_nextFreq = (w_sum >= {1'b0, r_fStop}) ? r_fStop : w_sum[F_W-1:0];
        else
            w_nextFreq = (w_diff[F_W] || (w_diff[F_W-1:0] <= r_fStop)) ? r_fStop : w_diff[F_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            f_set      <= FMIN_W;
            w_set      <= 1'b0;
            a_set      <= A_MUTE;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            r_fStart   <= FMIN_W;
            r_fStop    <= FMIN_W;
            r_fStep    <= '0;
            r_dwell    <= DWELL_W'(1);
            r_cnt      <= '0;
            r_up       <= 1'b1;
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
                a_set   <= A_MUTE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            if (w_cfgValid) begin
                                r_fStart <= w_startClamp;
                                r_fStop  <= w_stopClamp;
                                r_fStep  <= f_step;
                                r_dwell  <= w_dwellEff;
                                r_up     <= (w_startClamp <= w_stopClamp);
                                r_cnt    <= '0;
                                f_set    <= w_startClamp;
                                w_set    <= w_cfg;
                                a_set    <= a_cfg;
                                busy     <= 1'b1;
                                r_state  <= RUN;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (s_clk) begin
                            if (w_cntNext == r_dwell) begin
                                r_cnt <= '0;
                                if (f_set == r_fStop) begin
`ifdef SWEEP_LOOP_EN
                                    f_set      <= r_fStart;
                                    step_pulse <= 1'b1;
`else
                                    r_state <= DONE;
                                    done    <= 1'b1;
                                    busy    <= 1'b0;
                                    a_set   <= A_MUTE;
`endif
                                end else begin
                                    f_set      <= w_nextFreq;
                                    step_pulse <= 1'b1;
                                end
                            end else begin
                                r_cnt <= w_cntNext;
                            end
                        end
                    end
                    DONE: r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_func_gen_sweep_ctrl.sv
// Directed bench for func_gen_sweep_ctrl: expected frequency points are queued at sweep start
// and popped whenever the DUT presents a new point. Define SWEEP_LOOP_EN to exercise loop mode.
module tb_func_gen_sweep_ctrl;

    localparam int F_W     = 19;
    localparam int DWELL_W = 16;
    localparam int SPERIOD = 4;

    logic               clk;
    logic               rst;
    logic               s_clk;
    logic               start;
    logic               abort;
    logic [F_W-1:0]     f_start;
    logic [F_W-1:0]     f_stop;
    logic [F_W-1:0]     f_step;
    logic [DWELL_W-1:0] dwell;
    logic               w_cfg;
    logic [2:0]         a_cfg;
    logic [F_W-1:0]     f_set;
    logic               w_set;
    logic [2:0]         a_set;
    logic               busy;
    logic               step_pulse;
    logic               done;
    logic               cfg_err;

    func_gen_sweep_ctrl dut (
        .clk(clk), .rst(rst), .s_clk(s_clk), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .w_cfg(w_cfg), .a_cfg(a_cfg), .f_set(f_set), .w_set(w_set), .a_set(a_set),
        .busy(busy), .step_pulse(step_pulse), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int freqQ[$];
    int phase = 0;
    bit sApplied;
    bit prevBusy;
    int tickCnt = 0;
    int expDwell = 1;
    int expW = 0;
    int expA = 0;
    int stepCount = 0;
    int doneCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic popCheck(input string tag);
        int expF;
        if (freqQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s: observed f_set=%0d expected no new point", tag, f_set);
        end else begin
            expF = freqQ.pop_front();
            checkOutput(tag, f_set, expF);
        end
    endtask

    function automatic int clampF(input int v);
        if (v < 1) return 1;
        if (v > 50000) return 50000;
        return v;
    endfunction

    // Reference point sequence: clamped endpoints, stepping without overshooting f_stop.
    task automatic pushSweep(input int fs, input int fe, input int st, input int passes);
        int a = clampF(fs);
        int b = clampF(fe);
        int f;
        repeat (passes) begin
            f = a;
            freqQ.push_back(f);
            while (f != b) begin
                if (a <= b) f = (f + st >= b) ? b : f + st;
                else        f = (f - st <= b) ? b : f - st;
                freqQ.push_back(f);
            end
        end
    endtask

    // One clock: drive the sampling strobe, advance, then observe outputs 1 ns after the edge.
    task automatic applyStimulus();
        s_clk    = (phase == SPERIOD - 1);
        sApplied = s_clk;
        prevBusy = busy;
        @(posedge clk);
        #1;
        phase = (phase + 1) % SPERIOD;
        if (!rst) begin
            if (busy && !prevBusy) begin
                popCheck("first_point");
                checkOutput("w_set_run", w_set, expW);
                checkOutput("a_set_run", a_set, expA);
                tickCnt = 0;
            end else if (prevBusy && sApplied) begin
                tickCnt++;
            end
            if (step_pulse) begin
                stepCount++;
                checkOutput("dwell_hold", tickCnt, expDwell);
                tickCnt = 0;
                popCheck("step_point");
            end
            if (done) begin
                doneCount++;
                checkOutput("dwell_hold_last", tickCnt, expDwell);
                checkOutput("done_busy", busy, 0);
                checkOutput("done_mute", a_set, 7);
            end
        end
    endtask

    task automatic setCfg(input int fs, input int fe, input int st, input int dw, input int w, input int a);
        f_start = F_W'(fs);
        f_stop  = F_W'(fe);
        f_step  = F_W'(st);
        dwell   = DWELL_W'(dw);
        w_cfg   = w[0];
        a_cfg   = a[2:0];
        expDwell = (dw == 0) ? 1 : dw;
        expW = w;
        expA = a;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int n = 0;
        int d0 = doneCount;
        while (doneCount == d0 && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_done_seen"}, doneCount - d0, 1);
    endtask

    task automatic waitSteps(input int target, input int budget, input string tag);
        int n = 0;
        while (stepCount < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_steps_reached"}, stepCount, target);
    endtask

    initial begin
        int s0;
        int d0;
        int n;
        rst = 1'b1; s_clk = 1'b0; start = 1'b0; abort = 1'b0;
        setCfg(0, 0, 0, 0, 0, 0);
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checkOutput("rst_f_set", f_set, 1);
        checkOutput("rst_w_set", w_set, 0);
        checkOutput("rst_a_set", a_set, 7);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_step", step_pulse, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);

        // Invalid configurations are rejected with a single cfg_err pulse.
        setCfg(1000, 2000, 0, 2, 0, 1);
        pulseStart();
        checkOutput("zero_step_cfg_err", cfg_err, 1);
        checkOutput("zero_step_busy", busy, 0);
        checkOutput("zero_step_mute", a_set, 7);
        applyStimulus();
        checkOutput("cfg_err_pulse_len", cfg_err, 0);
        setCfg(1000, 2000, 100, 2, 0, 6);
        pulseStart();
        checkOutput("bad_amp_cfg_err", cfg_err, 1);
        checkOutput("bad_amp_busy", busy, 0);
        applyStimulus();

        // Abort coinciding with dwell expiry at 1200 stops cleanly.
        setCfg(1000, 1400, 100, 2, 0, 2);
        pushSweep(1000, 1400, 100, 1);
        s0 = stepCount;
        d0 = doneCount;
        pulseStart();
        n = 0;
        while (f_set != 1200 && n < 200) begin applyStimulus(); n++; end
        checkOutput("abort_reach_1200", f_set, 1200);
        n = 0;
        while (!(tickCnt == expDwell - 1 && phase == SPERIOD - 1) && n < 50) begin applyStimulus(); n++; end
        checkOutput("abort_align", tickCnt, expDwell - 1);
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_mute", a_set, 7);
        checkOutput("abort_no_step", step_pulse, 0);
        checkOutput("abort_no_done", done, 0);
        checkOutput("abort_f_hold", f_set, 1200);
        repeat (20) applyStimulus();
        checkOutput("abort_step_count", stepCount - s0, 2);
        checkOutput("abort_done_count", doneCount - d0, 0);
        checkOutput("abort_points_left", freqQ.size(), 2);
        freqQ.delete();

`ifdef SWEEP_LOOP_EN
        // Loop mode wraps 1200 -> 1000 with a step pulse and never signals done.
        setCfg(1000, 1200, 100, 2, 1, 3);
        pushSweep(1000, 1200, 100, 4);
        s0 = stepCount;
        d0 = doneCount;
        pulseStart();
        waitSteps(s0 + 9, 400, "loop");
        checkOutput("loop_wrapped_f", f_set, 1000);
        checkOutput("loop_no_done", doneCount - d0, 0);
        checkOutput("loop_busy", busy, 1);
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        checkOutput("loop_abort_busy", busy, 0);
        checkOutput("loop_abort_mute", a_set, 7);
        freqQ.delete();
        applyStimulus();
        pushSweep(1000, 1200, 100, 1);
        s0 = stepCount;
        pulseStart();
        waitSteps(s0 + 1, 100, "loop_restart");
`else
        // Upward sweep, sine, amplitude 1, dwell 3.
        setCfg(1000, 1400, 100, 3, 0, 1);
        pushSweep(1000, 1400, 100, 1);
        s0 = stepCount;
        pulseStart();
        waitDone(400, "up");
        checkOutput("up_step_count", stepCount - s0, 4);
        checkOutput("up_f_hold", f_set, 1400);
        checkOutput("up_points_left", freqQ.size(), 0);
        applyStimulus();
        checkOutput("up_done_pulse_len", done, 0);
        checkOutput("up_idle_mute", a_set, 7);

        // Downward sweep clamps the last step to f_stop; mid-sweep start/config changes ignored.
        setCfg(5000, 4000, 300, 1, 1, 4);
        pushSweep(5000, 4000, 300, 1);
        s0 = stepCount;
        pulseStart();
        applyStimulus();
        f_start = F_W'(9999);
        f_stop  = F_W'(10);
        f_step  = F_W'(1);
        pulseStart();
        waitDone(200, "down");
        checkOutput("down_step_count", stepCount - s0, 4);
        checkOutput("down_f_hold", f_set, 4000);
        checkOutput("down_w_hold", w_set, 1);
        checkOutput("down_points_left", freqQ.size(), 0);
        applyStimulus();

        // Out-of-range single point with zero dwell.
        setCfg(60000, 60000, 5, 0, 0, 0);
        pushSweep(60000, 60000, 5, 1);
        s0 = stepCount;
        pulseStart();
        waitDone(100, "single");
        checkOutput("single_step_count", stepCount - s0, 0);
        checkOutput("single_f_hold", f_set, 50000);
        applyStimulus();

        s0 = stepCount;
        setCfg(2000, 3000, 500, 1, 1, 5);
        pushSweep(2000, 3000, 500, 1);
        pulseStart();
        waitSteps(s0 + 1, 100, "rst_mid");
`endif
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("rst_mid_f_set", f_set, 1);
        checkOutput("rst_mid_w_set", w_set, 0);
        checkOutput("rst_mid_a_set", a_set, 7);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_step", step_pulse, 0);
        freqQ.delete();
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no completion expected finish before timeout");
        $fatal(1, "[TB] timeout");
    end

endmodule
